// File: rtl/sram_arb_pkg.sv
// Shared types and default sizes for the two-requester SRAM port arbiter.
package sram_arb_pkg;
    localparam int DEF_ADDR_WIDTH = 11;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_WMASKS = DEF_DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // 0 = m0 (instruction fetch), 1 = m1 (data bus)
    typedef logic req_id_t;
endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; ptr = 1 favours m1, and it moves only on advance.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       ptr
);
    always_comb begin
        grant = req;
        if (&req) grant = ptr ? 2'b10 : 2'b01;
    end

    // After a grant, favour whoever did not win.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= 1'b0;
        else if (advance && |grant)
            ptr <= grant[0];
    end
endmodule

// File: rtl/sram_port_arbiter.sv
// Shares a 1W/1R SRAM macro between m0 and m1, one transaction in flight,
// sequenced IDLE -> ISSUE -> WAIT -> RESP with all outputs registered.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_WMASKS = DEF_NUM_WMASKS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic [NUM_WMASKS-1:0] m0_wstrb,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic [NUM_WMASKS-1:0] m1_wstrb,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  busy,
    output logic                  sram_csb0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);
    state_t     state, state_nxt;
    logic [1:0] grant;
    logic       advance;
    logic       rr_ptr_unused;
    req_id_t    win_id;
    logic       win_we;

    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [NUM_WMASKS-1:0] sel_wstrb;

    rr_arbiter_2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({m1_req, m0_req}),
        .advance (advance),
        .grant   (grant),
        .ptr     (rr_ptr_unused)
    );

    assign advance   = (state == IDLE) && (|grant);
    assign sel_we    = grant[1] ? m1_we    : m0_we;
    assign sel_addr  = grant[1] ? m1_addr  : m0_addr;
    assign sel_wdata = grant[1] ? m1_wdata : m0_wdata;
    assign sel_wstrb = grant[1] ? m1_wstrb : m0_wstrb;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (advance) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The SRAM drive registers double as the request latch: loaded on the
    // grant edge so the chip select is low for exactly the ISSUE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            win_id      <= 1'b0;
            win_we      <= 1'b0;
            busy        <= 1'b0;
            m0_ack      <= 1'b0;
            m1_ack      <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
            sram_csb0   <= 1'b1;
            sram_csb1   <= 1'b1;
            sram_wmask0 <= '0;
            sram_addr0  <= '0;
            sram_din0   <= '0;
            sram_addr1  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (advance) begin
                    win_id <= grant[1];
                    win_we <= sel_we;
                    busy   <= 1'b1;
                    if (sel_we) begin
                        sram_csb0   <= 1'b0;
                        sram_wmask0 <= sel_wstrb;
                        sram_addr0  <= sel_addr;
                        sram_din0   <= sel_wdata;
                    end else begin
                        sram_csb1  <= 1'b0;
                        sram_addr1 <= sel_addr;
                    end
                end
                ISSUE: begin
                    sram_csb0 <= 1'b1;
                    sram_csb1 <= 1'b1;
                end
                WAIT: begin
                    if (!win_we) begin
                        if (win_id) m1_rdata <= sram_dout1;
                        else        m0_rdata <= sram_dout1;
                    end
                    m0_ack <= !win_id;
                    m1_ack <= win_id;
                end
                RESP: begin
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                    busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a negedge-access dual-port SRAM model.
module tb_sram_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [10:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ack, m1_ack, busy;
    logic [31:0] m0_rdata, m1_rdata;
    logic        sram_csb0, sram_csb1;
    logic [3:0]  sram_wmask0;
    logic [10:0] sram_addr0, sram_addr1;
    logic [31:0] sram_din0, sram_dout1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sram_port_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .busy(busy),
        .sram_csb0(sram_csb0), .sram_wmask0(sram_wmask0), .sram_addr0(sram_addr0),
        .sram_din0(sram_din0), .sram_csb1(sram_csb1), .sram_addr1(sram_addr1),
        .sram_dout1(sram_dout1)
    );

    // SRAM model: inputs registered at posedge, access at the following negedge.
    logic [31:0] mem [0:2047];
    logic        csb0_q, csb1_q;
    logic [3:0]  wm_q;
    logic [10:0] a0_q, a1_q;
    logic [31:0] d0_q;

    always @(posedge clk) begin
        csb0_q <= sram_csb0;
        csb1_q <= sram_csb1;
        wm_q   <= sram_wmask0;
        a0_q   <= sram_addr0;
        a1_q   <= sram_addr1;
        d0_q   <= sram_din0;
    end

    always @(negedge clk) begin
        if (csb0_q == 1'b0)
            for (int b = 0; b < 4; b++)
                if (wm_q[b]) mem[a0_q][8*b +: 8] <= d0_q[8*b +: 8];
        if (csb1_q == 1'b0)
            sram_dout1 <= mem[a1_q];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_csb0"}, 64'(sram_csb0), 64'd1);
        check({tag, "_csb1"}, 64'(sram_csb1), 64'd1);
        check({tag, "_wmask0"}, 64'(sram_wmask0), 64'd0);
        check({tag, "_addr0"}, 64'(sram_addr0), 64'd0);
        check({tag, "_din0"}, 64'(sram_din0), 64'd0);
        check({tag, "_addr1"}, 64'(sram_addr1), 64'd0);
        check({tag, "_acks"}, 64'({m1_ack, m0_ack}), 64'd0);
        check({tag, "_rdata0"}, 64'(m0_rdata), 64'd0);
        check({tag, "_rdata1"}, 64'(m1_rdata), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    // One transaction from an idle arbiter; exp_rd is the rdata expected with ack.
    task automatic txn(input bit m, input logic we, input logic [10:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb,
                       input logic [31:0] exp_rd, input string tag);
        int n = 0, c0 = 0, c1 = 0, other = 0;
        logic [31:0] rd = 'x;
        if (m) begin
            m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb;
        end else begin
            m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb;
        end
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (!sram_csb0) c0++;
            if (!sram_csb1) c1++;
            if (m ? m0_ack : m1_ack) other++;
            if (m ? m1_ack : m0_ack) begin
                n  = i;
                rd = m ? m1_rdata : m0_rdata;
                break;
            end
        end
        m0_req = 0; m1_req = 0;
        check({tag, "_latency"}, 64'(n), 64'd3);
        check({tag, "_csb0_cycles"}, 64'(c0), we ? 64'd1 : 64'd0);
        check({tag, "_csb1_cycles"}, 64'(c1), we ? 64'd0 : 64'd1);
        check({tag, "_other_ack"}, 64'(other), 64'd0);
        check({tag, "_rdata"}, 64'(rd), 64'(exp_rd));
        @(posedge clk); #1;
    endtask

    logic [15:0] ack0_v, ack1_v;
    logic [31:0] cap0, cap1;
    int          both;

    initial begin
        rst = 1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        rst = 0;
        @(posedge clk); #1;

        // m0 write then read back
        txn(0, 1, 11'h005, 32'hDEADBEEF, 4'hF, 32'h0, "m0_wr5");
        check("mem_005", 64'(mem[11'h005]), 64'hDEADBEEF);
        txn(0, 0, 11'h005, 32'h0, 4'h0, 32'hDEADBEEF, "m0_rd5");

        // preloads through the arbiter; m0_rdata must hold across writes
        txn(0, 1, 11'h010, 32'h11223344, 4'hF, 32'hDEADBEEF, "pre_010");
        txn(0, 1, 11'h7FF, 32'h00000000, 4'hF, 32'hDEADBEEF, "pre_7ff");
        txn(0, 1, 11'h000, 32'hCAFEF00D, 4'hF, 32'hDEADBEEF, "pre_000");
        txn(0, 1, 11'h001, 32'h11110001, 4'hF, 32'hDEADBEEF, "pre_001");
        txn(0, 1, 11'h002, 32'h22220002, 4'hF, 32'hDEADBEEF, "pre_002");

        // byte lanes 0 and 2 only
        txn(1, 1, 11'h010, 32'hAABBCCDD, 4'h5, 32'h0, "m1_bytewr");
        txn(1, 0, 11'h010, 32'h0, 4'h0, 32'h11BB33DD, "m1_byterd");

        // empty strobe: full sequence, memory and rdata untouched
        txn(1, 1, 11'h7FF, 32'hFFFFFFFF, 4'h0, 32'h11BB33DD, "m1_wstrb0");
        check("mem_7ff_unchanged", 64'(mem[11'h7FF]), 64'h0);

        // top and bottom of the address space stay distinct
        txn(0, 1, 11'h7FF, 32'h12345678, 4'hF, 32'hDEADBEEF, "m0_wr7ff");
        txn(0, 0, 11'h7FF, 32'h0, 4'h0, 32'h12345678, "m0_rd7ff");
        txn(0, 0, 11'h000, 32'h0, 4'h0, 32'hCAFEF00D, "m0_rd000");

        // contention with both requests held from reset
        rst = 1;
        m0_req = 1; m0_we = 0; m0_addr = 11'h001;
        m1_req = 1; m1_we = 0; m1_addr = 11'h002;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        ack0_v = '0; ack1_v = '0; both = 0; cap0 = 'x; cap1 = 'x;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            ack0_v[i] = m0_ack;
            ack1_v[i] = m1_ack;
            if (m0_ack && m1_ack) both++;
            if (m0_ack) cap0 = m0_rdata;
            if (m1_ack) cap1 = m1_rdata;
        end
        m0_req = 0; m1_req = 0;
        check("cont_ack0_pattern", 64'(ack0_v), 64'h0404);
        check("cont_ack1_pattern", 64'(ack1_v), 64'h4040);
        check("cont_both_acks", 64'(both), 64'd0);
        check("cont_rdata0", 64'(cap0), 64'h11110001);
        check("cont_rdata1", 64'(cap1), 64'h22220002);

        // reset lands while an m1 read is in WAIT
        @(posedge clk); #1;
        m1_req = 1; m1_we = 0; m1_addr = 11'h002;
        @(posedge clk); #1;
        check("abort_issue_csb1", 64'(sram_csb1), 64'd0);
        @(posedge clk); #1;
        check("abort_wait_busy", 64'(busy), 64'd1);
        rst = 1; m1_req = 0;
        @(posedge clk); #1;
        check_reset("abort");
        rst = 0;
        @(posedge clk); #1;
        check("abort_no_ack", 64'({m1_ack, m0_ack}), 64'd0);

        m0_req = 1; m0_we = 0; m0_addr = 11'h001;
        m1_req = 1; m1_we = 0; m1_addr = 11'h002;
        ack0_v = '0; ack1_v = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            ack0_v[i] = m0_ack;
            ack1_v[i] = m1_ack;
        end
        m0_req = 0; m1_req = 0;
        check("post_rst_ack0", 64'(ack0_v), 64'h0004);
        check("post_rst_ack1", 64'(ack1_v), 64'h0040);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
